display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Sequences the 8-digit 7-segment display. Drives the 3-bit nibble select into the
//  address/data nibble mux and the active-low digit anodes. Holds a tear-free shadow of
//  the 32-bit display word, committed only at frame boundaries. Inserts a ghosting guard
//  interval (all anodes off) between digits.
// PARAMETERS
//  ON_CYC     default 100000  clocks each digit is lit; legal range >= 1
//  BLANK_CYC  default 1000    clocks all anodes are off before each digit; 0 = no guard
// PORTS
//  clk         in   1   system clock; all logic rising-edge
//  reset       in   1   synchronous, active-high
//  data_in     in   32  new display word {addr, data}
//  load        in   1   1-cycle request to stage data_in
//  load_ack    out  1   1-cycle pulse when the staged word is committed to disp_data
//  digit_en    in   8   per-digit enable; bit k = digit k may light
//  sel         out  3   nibble select to the mux; 0 = data[3:0], 7 = data[31:28]
//  disp_data   out  32  committed display word, fed to the mux data input
//  anode       out  8   active-low digit drive; bit k lights digit k
//  frame_done  out  1   1-cycle pulse on the last ON cycle of digit 7
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//  - Reset values: sel=0, state=BLANK, cnt=0, anode=8'hFF, disp_data=0, stage=0,
//    pending=0, load_ack=0, frame_done=0.
//  - Reset mid-frame: same values on the next edge; staged data is discarded.
//  - Registered outputs: every output is a register. sel and anode change on the same edge.
//  - FSM states: BLANK and ON.
//    * BLANK: anode=8'hFF for BLANK_CYC clocks, then ON.
//    * BLANK_CYC=0: BLANK is skipped and ON directly follows ON.
//    * ON: anode[sel]=0 for ON_CYC clocks if digit_en[sel]=1; otherwise anode=8'hFF.
//      All other anode bits are 1.
//    * Last ON cycle: sel <= sel+1. The sel value 7 wraps to 0 (3-bit modulo). Next state is BLANK.
//  - Frame length: exactly 8*(BLANK_CYC+ON_CYC) clocks. The first frame after reset starts in BLANK with sel=0.
//  - Counter: cnt is wide enough for max(ON_CYC,BLANK_CYC)-1. It clears on every state change.
//  - Frame boundary: the last ON cycle of sel=7. On that cycle:
//    * frame_done=1 for one cycle.
//    * If pending=1: disp_data <= stage, pending <= 0, load_ack=1 for one cycle.
//  - Load handling:
//    * load=1 writes stage <= data_in and sets pending=1.
//    * A second load before commit overwrites stage (latest wins). Only one load_ack is issued.
//  - Load coinciding with frame boundary: the old stage commits to disp_data. The new data_in
//    goes to stage and pending stays 1, so it commits at the next boundary.
//  - digit_en change: takes effect at the next edge (next ON cycle evaluated).
// CONFIGURATION
//  LZ_BLANK_EN defined:
//   - Leading-zero blanking. Digit k (k>=1) is forced off (anode bit = 1) when
//     disp_data[31:4k] == 0.
//   - Digit 0 is never blanked by this rule. digit_en still applies.
//  LZ_BLANK_EN undefined:
//   - Only digit_en gates anodes. No zero detection logic is present.
// TESTING
//  T1 reset: assert reset 2 clks mid-ON at sel=5 -> sel=0, anode=FF, disp_data=0, no pulses.
//  T2 timing (ON_CYC=4, BLANK_CYC=2, digit_en=FF):
//     -> anode FF for 2 clks, FE for 4 clks, FF for 2 clks, FD for 4 clks, ...
//     -> frame_done pulses every 48 clks.
//  T3 digit_en=8'h0F -> digits 0-3 lit in sequence; anode=FF throughout slots 4-7.
//     Sel still steps 0..7.
//  T4 load 32'hDEAD_BEEF mid-frame:
//     -> disp_data unchanged until the frame boundary.
//     -> Then DEADBEEF with load_ack and frame_done in the same cycle.
//  T5 load 32'h1111_1111 then 32'h2222_2222 in the same frame -> one load_ack, disp_data=22222222.
//     Load 32'h3333_3333 on the boundary cycle -> disp_data=22222222 now, 33333333 next frame.
//  T6 (LZ_BLANK_EN) disp_data=32'h0000_0120, digit_en=FF -> digits 0-2 lit, 3-7 anode=FF.
//     disp_data=0 -> only digit 0 lit.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Scan sequencer for an 8-digit 7-segment display with a frame-synchronous shadow word
// and an all-off guard slot before each digit. Optional macro: LZ_BLANK_EN (leading-zero blanking).
module display_scan_ctrl #(
    parameter int ON_CYC    = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    input  logic        load,
    output logic        load_ack,
    input  logic [7:0]  digit_en,
    output logic [2:0]  sel,
    output logic [31:0] disp_data,
    output logic [7:0]  anode,
    output logic        frame_done
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? (BLANK_CYC - 1) : 0);

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [2:0]    sel_n;
    logic          last_on;
    logic          boundary;
    logic [31:0]   stage;
    logic          pending;
    logic [31:0]   disp_n;
    logic [7:0]    anode_n;

`ifdef LZ_BLANK_EN
    // Digit k>=1 stays dark when every nibble from k upward is zero.
    function automatic logic lz_lit(input logic [31:0] word, input logic [2:0] k);
        logic [31:0] upper;
        upper = word >> {k, 2'b00};
        return (k == 3'd0) || (upper != 32'd0);
    endfunction
`endif

    // Next-state, counter and digit-select sequencing.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + {{(CW-1){1'b0}}, 1'b1};
        sel_n   = sel;
        last_on = 1'b0;
        case (state)
            BLANK: begin
                if ((BLANK_CYC == 0) || (cnt == BLANK_LAST)) begin
                    state_n = ON;
                    cnt_n   = {CW{1'b0}};
                end else begin
                    state_n = BLANK;
                end
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    last_on = 1'b1;
                    sel_n   = sel + 3'd1;
                    cnt_n   = {CW{1'b0}};
                    state_n = (BLANK_CYC == 0) ? ON : BLANK;
                end else begin
                    state_n = ON;
                end
            end
            default: begin
                state_n = BLANK;
                cnt_n   = {CW{1'b0}};
            end
        endcase
    end

    assign boundary = last_on && (sel == 3'd7);

    // Commit value and anode drive for the upcoming cycle, so outputs stay registered.
    always_comb begin
        disp_n  = (boundary && pending) ? stage : disp_data;
        anode_n = 8'hFF;
`ifdef LZ_BLANK_EN
        if ((state_n == ON) && digit_en[sel_n] && lz_lit(disp_n, sel_n)) begin
`else
        if ((state_n == ON) && digit_en[sel_n]) begin
`endif
            anode_n[sel_n] = 1'b0;
        end else begin
            anode_n = 8'hFF;
        end
    end

    // State, staging and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK;
            cnt        <= {CW{1'b0}};
            sel        <= 3'd0;
            anode      <= 8'hFF;
            disp_data  <= 32'd0;
            stage      <= 32'd0;
            pending    <= 1'b0;
            load_ack   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sel        <= sel_n;
            anode      <= anode_n;
            disp_data  <= disp_n;
            load_ack   <= boundary && pending;
            frame_done <= boundary;
            if (load) begin
                stage   <= data_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end else begin
                pending <= pending;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized self-checking bench for display_scan_ctrl (ON_CYC=4, BLANK_CYC=2) against a
// position-in-frame reference model.
module tb_display_scan_ctrl;

    localparam int TON    = 4;
    localparam int TBLANK = 2;
    localparam int SLOT   = TON + TBLANK;
    localparam int FRAME  = 8 * SLOT;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_in;
    logic        load;
    logic        load_ack;
    logic [7:0]  digit_en;
    logic [2:0]  sel;
    logic [31:0] disp_data;
    logic [7:0]  anode;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          pos;
    logic [31:0] m_disp;
    logic [31:0] m_stage;
    logic        m_pend;
    logic        e_ack;
    logic        e_fd;
    logic [2:0]  e_sel;
    logic [7:0]  e_anode;

    display_scan_ctrl #(.ON_CYC(TON), .BLANK_CYC(TBLANK)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .load_ack(load_ack),
        .digit_en(digit_en), .sel(sel), .disp_data(disp_data), .anode(anode),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic digit_may_light(input logic [31:0] word, input int k);
`ifdef LZ_BLANK_EN
        return (k == 0) || ((word >> (4 * k)) != 32'd0);
`else
        return 1'b1;
`endif
    endfunction

    // One clock with the given inputs; model then predicts the outputs after the edge.
    task automatic tick(input logic ld, input logic [31:0] din, input logic [7:0] en);
        logic bnd;
        reset    = 1'b0;
        load     = ld;
        data_in  = din;
        digit_en = en;
        @(posedge clk);
        bnd   = ((pos % FRAME) == FRAME - 1);
        e_fd  = bnd;
        e_ack = bnd && m_pend;
        if (bnd && m_pend) begin
            m_disp = m_stage;
            m_pend = 1'b0;
        end
        if (ld) begin
            m_stage = din;
            m_pend  = 1'b1;
        end
        pos     = pos + 1;
        e_sel   = 3'((pos / SLOT) % 8);
        e_anode = 8'hFF;
        if (((pos % SLOT) >= TBLANK) && en[e_sel] && digit_may_light(m_disp, int'(e_sel)))
            e_anode[e_sel] = 1'b0;
        #1;
    endtask

    task automatic reset_tick(input logic ld);
        reset   = 1'b1;
        load    = ld;
        data_in = $urandom;
        @(posedge clk);
        pos = 0; m_disp = 32'd0; m_stage = 32'd0; m_pend = 1'b0;
        e_ack = 1'b0; e_fd = 1'b0; e_sel = 3'd0; e_anode = 8'hFF;
        #1;
    endtask

    task automatic test_reset();
        reset_tick(1'b0);
        reset_tick(1'b0);
        total++;
        if (sel !== 3'd0 || anode !== 8'hFF || disp_data !== 32'd0 || load_ack !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: sel=%0d anode=%h disp=%h ack=%b fd=%b, want 0 FF 0 0 0",
                     sel, anode, disp_data, load_ack, frame_done);
        end
    endtask

    task automatic test_timing();
        int fd_seen = 0;
        for (int i = 0; i < 2 * FRAME + 3; i++) begin
            tick(1'b0, $urandom, 8'hFF);
            total++;
            if (anode !== e_anode || sel !== e_sel) begin
                bad++;
                $display("FAIL timing pos=%0d: anode=%h sel=%0d, want %h %0d", pos, anode, sel, e_anode, e_sel);
            end
            total++;
            if (frame_done !== e_fd || load_ack !== 1'b0) begin
                bad++;
                $display("FAIL frame_pulse pos=%0d: fd=%b ack=%b, want %b 0", pos, frame_done, load_ack, e_fd);
            end
            if (frame_done === 1'b1) fd_seen++;
        end
        total++;
        if (fd_seen != 2) begin
            bad++;
            $display("FAIL frame_count: got %0d frame_done pulses, want 2", fd_seen);
        end
    endtask

    task automatic test_digit_en();
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b0, 32'd0, 8'h0F);
            total++;
            if (anode !== e_anode || sel !== e_sel) begin
                bad++;
                $display("FAIL digit_en pos=%0d: anode=%h sel=%0d, want %h %0d", pos, anode, sel, e_anode, e_sel);
            end
        end
    endtask

    task automatic run_to_boundary_and_check(input string name);
        for (int i = 0; i < FRAME + 2; i++) begin
            tick(1'b0, $urandom, 8'hFF);
            total++;
            if (disp_data !== m_disp || load_ack !== e_ack || frame_done !== e_fd || anode !== e_anode) begin
                bad++;
                $display("FAIL %s pos=%0d: disp=%h ack=%b fd=%b anode=%h, want %h %b %b %h",
                         name, pos, disp_data, load_ack, frame_done, anode, m_disp, e_ack, e_fd, e_anode);
            end
        end
    endtask

    task automatic test_load_mid();
        int n = $urandom_range(5, 20);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0, 8'hFF);
        tick(1'b1, 32'hDEAD_BEEF, 8'hFF);
        run_to_boundary_and_check("load_mid");
        total++;
        if (disp_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL load_mid_value: disp=%h, want deadbeef", disp_data);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        while ((pos % FRAME) != 10) tick(1'b0, 32'd0, 8'hFF);
        tick(1'b1, 32'h1111_1111, 8'hFF);
        tick(1'b0, 32'd0, 8'hFF);
        tick(1'b1, 32'h2222_2222, 8'hFF);
        while ((pos % FRAME) != FRAME - 1) begin
            tick(1'b0, 32'd0, 8'hFF);
            if (load_ack === 1'b1) acks++;
        end
        tick(1'b1, 32'h3333_3333, 8'hFF);
        if (load_ack === 1'b1) acks++;
        total++;
        if (disp_data !== 32'h2222_2222 || load_ack !== 1'b1 || acks != 1) begin
            bad++;
            $display("FAIL latest_wins: disp=%h ack=%b acks=%0d, want 22222222 1 1", disp_data, load_ack, acks);
        end
        run_to_boundary_and_check("boundary_load");
        total++;
        if (disp_data !== 32'h3333_3333) begin
            bad++;
            $display("FAIL boundary_load_value: disp=%h, want 33333333", disp_data);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6 * FRAME; i++) begin
            tick(($urandom_range(0, 29) == 0), $urandom, 8'($urandom));
            total++;
            if (anode !== e_anode || sel !== e_sel || disp_data !== m_disp ||
                load_ack !== e_ack || frame_done !== e_fd) begin
                bad++;
                $display("FAIL random pos=%0d: anode=%h sel=%0d disp=%h ack=%b fd=%b, want %h %0d %h %b %b",
                         pos, anode, sel, disp_data, load_ack, frame_done, e_anode, e_sel, m_disp, e_ack, e_fd);
            end
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b1, 32'hCAFE_F00D, 8'hFF);
        while ((pos % FRAME) != 5 * SLOT + TBLANK + 1) tick(1'b0, 32'd0, 8'hFF);
        for (int i = 0; i < 2; i++) begin
            reset_tick(1'b1);
            total++;
            if (sel !== 3'd0 || anode !== 8'hFF || disp_data !== 32'd0 || load_ack !== 1'b0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset: sel=%0d anode=%h disp=%h ack=%b fd=%b, want 0 FF 0 0 0",
                         sel, anode, disp_data, load_ack, frame_done);
            end
        end
        run_to_boundary_and_check("after_reset");
    endtask

`ifdef LZ_BLANK_EN
    task automatic test_lz();
        tick(1'b1, 32'h0000_0120, 8'hFF);
        run_to_boundary_and_check("lz_0120");
        tick(1'b1, 32'h0000_0000, 8'hFF);
        run_to_boundary_and_check("lz_zero");
    endtask
`endif

    initial begin
        reset = 1'b1; load = 1'b0; data_in = 32'd0; digit_en = 8'hFF; pos = 0;
        m_disp = 32'd0; m_stage = 32'd0; m_pend = 1'b0;
        test_reset();
        test_timing();
        test_digit_en();
        test_load_mid();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef LZ_BLANK_EN
        test_lz();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
